// File: rtl/seven_seg_bcd_counter_if.sv
// Control inputs and display/count outputs of the seven-segment BCD counter.
// Pure wiring: no state, no added latency.
// No backpressure: plain level signals sampled every clock.
interface seven_seg_bcd_counter_if #(
  parameter int DIGITS = 4
);
  // Control side
  logic                  count_en;
  logic                  up_down;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;

  // Display / status side
  logic [7:0]            Anode_Activate;
  logic [6:0]            LED_out;
  logic [4*DIGITS-1:0]   bcd_value;
  logic                  wrap;

  // Driver of the controls, consumer of the display
  modport master (
    output count_en,
    output up_down,
    output clear,
    output load,
    output load_value,
    input  Anode_Activate,
    input  LED_out,
    input  bcd_value,
    input  wrap
  );

  // The counter itself
  modport slave (
    input  count_en,
    input  up_down,
    input  clear,
    input  load,
    input  load_value,
    output Anode_Activate,
    output LED_out,
    output bcd_value,
    output wrap
  );
endinterface

// File: rtl/seven_seg_bcd_counter.sv
// Prescaled up/down BCD counter with multiplexed active-low seven-segment scan.
// Count and wrap update on the tick edge; anode/cathode outputs lag index and count by one clock.
// No backpressure: controls are sampled every clock, priority clear > load > tick.
module seven_seg_bcd_counter #(
  parameter int CLK_HZ       = 100000000,
  parameter int TICK_HZ      = 1,
  parameter int DIGITS       = 4,
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_LZ     = 1
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset,
  seven_seg_bcd_counter_if.slave bus
);

  // Prescaler divides the clock down to one tick per count period.
  localparam int             DIV       = CLK_HZ / TICK_HZ;
  localparam int             PW        = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

  // Digit index is kept at least one bit wide so DIGITS=1 still elaborates.
  localparam int             IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0]  IDX_MAX   = IW'(DIGITS - 1);

  logic [PW-1:0]              presc_q;
  logic                       tick;

  logic [DIGITS-1:0][3:0]     cnt_q;
  logic [DIGITS-1:0][3:0]     cnt_inc;
  logic [DIGITS-1:0][3:0]     cnt_dec;
  logic [DIGITS-1:0][3:0]     load_clean;
  logic                       carry;
  logic                       borrow;
  logic                       wrap_q;

  logic [REFRESH_BITS-1:0]    refresh_q;
  logic [IW-1:0]              idx_q;

  logic [DIGITS-1:0]          blank;
  logic                       hi_zero;
  logic [3:0]                 cur_dig;
  logic                       cur_blank;
  logic [7:0]                 anode_nxt;
  logic [6:0]                 seg_nxt;
  logic [7:0]                 anode_q;
  logic [6:0]                 seg_q;

  // Active-low cathode pattern (a..g on bits 6..0); non-decimal codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Tick fires on the terminal prescaler count, and only while counting is enabled.
  assign tick = bus.count_en && (presc_q == PRESC_MAX);

  // Prescaler: clear restarts the period; otherwise it runs only while enabled.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else if (bus.clear) begin
      presc_q <= '0;
    end else if (bus.count_en) begin
      presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  // Next-count candidates: decimal ripple increment/decrement and a sanitised load value.
  always_comb begin
    cnt_inc    = cnt_q;
    cnt_dec    = cnt_q;
    load_clean = '0;
    carry      = 1'b1;
    borrow     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (cnt_q[k] == 4'd9) begin
          cnt_inc[k] = 4'd0;
        end else begin
          cnt_inc[k] = cnt_q[k] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt_q[k] == 4'd0) begin
          cnt_dec[k] = 4'd9;
        end else begin
          cnt_dec[k] = cnt_q[k] - 4'd1;
          borrow     = 1'b0;
        end
      end
      // Non-BCD nibbles are stored as zero so the count is always valid BCD.
      load_clean[k] = (bus.load_value[4*k +: 4] > 4'd9) ? 4'd0 : bus.load_value[4*k +: 4];
    end
  end

  // Count register and single-cycle wrap pulse; carry/borrow surviving every digit means a wrap.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.clear) begin
        cnt_q <= '0;
      end else if (bus.load) begin
        cnt_q <= load_clean;
      end else if (tick) begin
        if (bus.up_down) begin
          cnt_q  <= cnt_inc;
          wrap_q <= carry;
        end else begin
          cnt_q  <= cnt_dec;
          wrap_q <= borrow;
        end
      end
    end
  end

  // Free-running scan: the digit index steps once per full refresh-counter period.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      refresh_q <= refresh_q + REFRESH_BITS'(1);
      if (&refresh_q) begin
        idx_q <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen so far is zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero && (cnt_q[k] == 4'd0);
      if ((k > 0) && (BLANK_LZ != 0)) begin
        blank[k] = hi_zero;
      end
    end
  end

  // Select the digit under the scan index and form the next anode/cathode drive.
  always_comb begin
    cur_dig   = cnt_q[0];
    cur_blank = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_dig   = cnt_q[k];
        cur_blank = blank[k];
      end
    end
    anode_nxt        = 8'hFF;
    anode_nxt[idx_q] = 1'b0;
    seg_nxt          = cur_blank ? 7'b1111111 : seg_decode(cur_dig);
  end

  // Registered display outputs so the pins change glitch-free, one clock behind the scan.
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      anode_q <= 8'hFF;
      seg_q   <= 7'b1111111;
    end else begin
      anode_q <= anode_nxt;
      seg_q   <= seg_nxt;
    end
  end

  assign bus.bcd_value      = cnt_q;
  assign bus.wrap           = wrap_q;
  assign bus.Anode_Activate = anode_q;
  assign bus.LED_out        = seg_q;

endmodule
